// File: rtl/dvp_rgb565_packer_if.sv
// rtl/dvp_rgb565_packer_if.sv - frame sync, line/pixel strobe and data bundle for DVP-style streams
interface dvp_rgb565_packer_if #(
   parameter int DW = 8
);
   logic          vsync;
   logic          href;
   logic [DW-1:0] data;

   modport master (output vsync, output href, output data);
   modport slave  (input  vsync, input  href, input  data);
endinterface

// File: rtl/dvp_rgb565_packer.sv
// rtl/dvp_rgb565_packer.sv - camera DVP byte capture, RGB565 pixel packing, geometry checks
module dvp_rgb565_packer #(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480,
   parameter bit BYTE_ORDER = 1'b0,
   parameter bit VSYNC_POL  = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   dvp_rgb565_packer_if.slave  cam,
   dvp_rgb565_packer_if.master pix,
   input  logic                capture_en,
   input  logic                err_clear,
   output logic [15:0]         frame_cnt,
   output logic [11:0]         line_len_last,
   output logic [2:0]          err_flags
);
   localparam logic [11:0] W = 12'(IMG_WIDTH);
   localparam logic [11:0] H = 12'(IMG_HEIGHT);

   typedef enum logic [1:0] {WAIT_VSYNC, FRAME, SKIP} state_t;
   state_t state, state_nxt;

   logic        r_vact, p_vact, r_href, p_href;
   logic [7:0]  r_data, hold;
   logic        phase, line_act;
   logic [11:0] col, row;

   logic        vact_in, vsync_rise, href_rise, href_fall, byte_ok, cur_phase, emit;
   logic [11:0] cur_col;
   logic [15:0] pair;
   logic [2:0]  err_set;

   always_ff @(posedge clk) begin
      if (rst) state <= WAIT_VSYNC;
      else     state <= state_nxt;
   end

   always_comb begin
      vact_in    = VSYNC_POL ? cam.vsync : ~cam.vsync;
      vsync_rise = r_vact & ~p_vact;
      href_rise  = r_href & ~p_href;
      // A line only exists after its own href rise; vsync aborts it.
      href_fall  = ~r_href & p_href & line_act;
      byte_ok    = r_href & (line_act | href_rise) & ~vsync_rise;
      cur_phase  = href_rise ? 1'b0 : phase;
      cur_col    = href_rise ? 12'd0 : col;
      pair       = BYTE_ORDER ? {r_data, hold} : {hold, r_data};
      emit       = byte_ok & cur_phase & (state == FRAME) & (cur_col < W) & (row < H);
      err_set    = 3'b000;
      if (state == FRAME && href_fall && !vsync_rise) begin
         err_set[0] = phase;
         err_set[1] = (col != W);
      end
      if (state == FRAME && vsync_rise && row != H) err_set[2] = 1'b1;
      state_nxt = state;
      if (vsync_rise) state_nxt = capture_en ? FRAME : SKIP;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_vact        <= 1'b0;
         p_vact        <= 1'b0;
         r_href        <= 1'b0;
         p_href        <= 1'b0;
         r_data        <= 8'h00;
         hold          <= 8'h00;
         phase         <= 1'b0;
         line_act      <= 1'b0;
         col           <= 12'd0;
         row           <= 12'd0;
         pix.vsync     <= 1'b0;
         pix.href      <= 1'b0;
         pix.data      <= 16'h0000;
         frame_cnt     <= 16'h0000;
         line_len_last <= 12'd0;
         err_flags     <= 3'b000;
      end else begin
         r_vact    <= vact_in;
         p_vact    <= r_vact;
         r_href    <= cam.href;
         p_href    <= r_href;
         r_data    <= cam.data;
         pix.vsync <= vsync_rise & capture_en;
         pix.href  <= emit;
         pix.data  <= emit ? pair : 16'h0000;
         err_flags <= (err_flags & ~{3{err_clear}}) | err_set;
         if (vsync_rise) begin
            line_act <= 1'b0;
            phase    <= 1'b0;
            col      <= 12'd0;
            row      <= 12'd0;
            if (capture_en) frame_cnt <= frame_cnt + 16'd1;
         end else begin
            if (href_rise) line_act <= 1'b1;
            if (byte_ok) begin
               phase <= ~cur_phase;
               if (!cur_phase) hold <= r_data;
               if (cur_phase && cur_col != 12'hFFF) col <= cur_col + 12'd1;
               else                                 col <= cur_col;
            end
            if (href_fall) begin
               line_act      <= 1'b0;
               phase         <= 1'b0;
               line_len_last <= col;
               if (state == FRAME && row != 12'hFFF) row <= row + 12'd1;
            end
         end
      end
   end
endmodule
